// File: rtl/tqvp_wdt_pkg.sv
// Shared definitions for the multi-channel windowed watchdog: register map,
// CTRL bit positions, tap magic and the per-channel status struct.
package tqvp_wdt_pkg;

  localparam logic [3:0] OFS_CTRL   = 4'h0;
  localparam logic [3:0] OFS_RELOAD = 4'h4;
  localparam logic [3:0] OFS_WINDOW = 4'h8;
  localparam logic [3:0] OFS_TAP    = 4'hC;

  localparam logic [5:0] ADDR_STATUS   = 6'h30;
  localparam logic [5:0] ADDR_PRESCALE = 6'h34;
  localparam logic [5:0] ADDR_INT_CLR  = 6'h38;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_START = 1;
  localparam int CTRL_WIN   = 2;
  localparam int CTRL_LOCK  = 3;

  localparam logic [31:0] TAP_MAGIC_DEF = 32'h0000_ABCD;

  typedef struct packed {
    logic bite;
    logic early_flt;
    logic bark;
    logic nz;
  } wdt_status_t;

  // Byte and half writes zero-extend into the 32-bit write bus.
  function automatic logic [31:0] wdata_ext(input logic [1:0] wn, input logic [31:0] d);
    case (wn)
      2'b00:   return {24'b0, d[7:0]};
      2'b01:   return {16'b0, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/tqvp_wdt_channel.sv
// One watchdog channel: countdown, bark/bite escalation, window check and lock.
module tqvp_wdt_channel
  import tqvp_wdt_pkg::*;
#(
  parameter int          CNT_W     = 32,
  parameter logic [31:0] TAP_MAGIC = TAP_MAGIC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             wr_ctrl_i,
  input  logic             wr_reload_i,
  input  logic             wr_window_i,
  input  logic             wr_tap_i,
  input  logic [31:0]      wdata_i,
  input  logic             clr_bark_i,
  input  logic             clr_flt_i,
  output wdt_status_t      status_o,
  output logic [3:0]       ctrl_o,
  output logic [CNT_W-1:0] reload_o,
  output logic [CNT_W-1:0] window_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic             enable_q, enable_d, started_q, started_d;
  logic             win_en_q, win_en_d, lock_q, lock_d;
  logic             bark_q, bark_d, bite_q, bite_d, flt_q, flt_d;
  logic [CNT_W-1:0] reload_q, reload_d, window_q, window_d, cnt_q, cnt_d;
  logic             ctrl_wr, tap_ok, early, tap_reload, run, expire;

  always_comb begin
    ctrl_wr    = wr_ctrl_i && !lock_q;
    tap_ok     = wr_tap_i && (wdata_i == TAP_MAGIC) && started_q;
    early      = win_en_q && (cnt_q > window_q);
    tap_reload = tap_ok && !early;
    run        = enable_q && started_q && !bite_q && tick_i && (cnt_q != '0);
    // A valid tap landing on the expiry cycle suppresses the expiry.
    expire     = run && (cnt_q == CNT_W'(1)) && !tap_reload;

    enable_d  = enable_q;
    started_d = started_q;
    win_en_d  = win_en_q;
    lock_d    = lock_q;
    reload_d  = reload_q;
    window_d  = window_q;
    cnt_d     = cnt_q;

    if (ctrl_wr) begin
      enable_d = wdata_i[CTRL_EN];
      win_en_d = wdata_i[CTRL_WIN];
      lock_d   = wdata_i[CTRL_LOCK];
    end
    if (wr_reload_i && !lock_q) reload_d = wdata_i[CNT_W-1:0];
    if (wr_window_i && !lock_q) window_d = wdata_i[CNT_W-1:0];

    if (tap_reload)
      cnt_d = reload_q;
    else if (run)
      cnt_d = (cnt_q == CNT_W'(1) && !bark_q) ? reload_q : cnt_q - CNT_W'(1);

    if (ctrl_wr && wdata_i[CTRL_START] && reload_q != '0) begin
      enable_d  = 1'b1;
      started_d = 1'b1;
      cnt_d     = reload_q;
    end

    bark_d = bark_q;
    if (tap_reload || clr_bark_i) bark_d = 1'b0;
    if (expire && !bark_q)        bark_d = 1'b1;
    bite_d = bite_q | (expire & bark_q);
    flt_d  = flt_q;
    if (clr_flt_i)      flt_d = 1'b0;
    if (tap_ok && early) flt_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q  <= 1'b0;
      started_q <= 1'b0;
      win_en_q  <= 1'b0;
      lock_q    <= 1'b0;
      bark_q    <= 1'b0;
      bite_q    <= 1'b0;
      flt_q     <= 1'b0;
      reload_q  <= '0;
      window_q  <= '0;
      cnt_q     <= '0;
    end else begin
      enable_q  <= enable_d;
      started_q <= started_d;
      win_en_q  <= win_en_d;
      lock_q    <= lock_d;
      bark_q    <= bark_d;
      bite_q    <= bite_d;
      flt_q     <= flt_d;
      reload_q  <= reload_d;
      window_q  <= window_d;
      cnt_q     <= cnt_d;
    end
  end

  assign status_o = '{bite: bite_q, early_flt: flt_q, bark: bark_q, nz: (cnt_q != '0)};
  assign ctrl_o   = {lock_q, win_en_q, started_q, enable_q};
  assign reload_o = reload_q;
  assign window_o = window_q;
  assign cnt_o    = cnt_q;

endmodule

// File: rtl/tqvp_wdt_multi.sv
// Multi-channel windowed watchdog on the TinyQV peripheral bus: shared
// prescaler, register decode, registered read mux and interrupt/bite outputs.
module tqvp_wdt_multi
  import tqvp_wdt_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter int          CNT_W     = 32,
  parameter int          PRESC_W   = 16,
  parameter logic [31:0] TAP_MAGIC = TAP_MAGIC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  logic                             wr_en, tick, wr_intclr, any_flag;
  logic [31:0]                      wdata, rdata, status_w, data_out_q;
  logic                             data_ready_q, irq_q;
  logic [PRESC_W-1:0]               presc_q, pcnt_q;
  logic [7:0]                       uo_w;
  wdt_status_t [NUM_CH-1:0]         st;
  logic [NUM_CH-1:0][3:0]           ctrl_v;
  logic [NUM_CH-1:0][CNT_W-1:0]     reload_v, window_v, cnt_v;
  logic                             unused_ok;

  assign unused_ok = &{1'b0, ui_in};
  assign wr_en     = (data_write_n != 2'b11);
  assign wdata     = wdata_ext(data_write_n, data_in);
  assign wr_intclr = wr_en && (address == ADDR_INT_CLR);
  assign tick      = (pcnt_q == presc_q);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel;
    assign sel = wr_en && (address[5:4] == 2'(c));
    tqvp_wdt_channel #(.CNT_W(CNT_W), .TAP_MAGIC(TAP_MAGIC)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_i     (tick),
      .wr_ctrl_i  (sel && address[3:0] == OFS_CTRL),
      .wr_reload_i(sel && address[3:0] == OFS_RELOAD),
      .wr_window_i(sel && address[3:0] == OFS_WINDOW),
      .wr_tap_i   (sel && address[3:0] == OFS_TAP),
      .wdata_i    (wdata),
      .clr_bark_i (wr_intclr && wdata[2*c]),
      .clr_flt_i  (wr_intclr && wdata[2*c+1]),
      .status_o   (st[c]),
      .ctrl_o     (ctrl_v[c]),
      .reload_o   (reload_v[c]),
      .window_o   (window_v[c]),
      .cnt_o      (cnt_v[c])
    );
  end

  always_comb begin
    status_w = '0;
    uo_w     = '0;
    any_flag = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      status_w[4*c +: 4] = st[c];
      uo_w[c]            = st[c].bite;
      any_flag           = any_flag | st[c].bark | st[c].early_flt;
    end
    status_w[31] = ctrl_v[0][CTRL_LOCK];
  end

  // TAP reads back the live counter; unmapped offsets read all ones.
  always_comb begin
    rdata = '1;
    if (address == ADDR_STATUS)        rdata = status_w;
    else if (address == ADDR_PRESCALE) rdata = 32'(presc_q);
    else if (address == ADDR_INT_CLR)  rdata = '0;
    else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (address[5:4] == 2'(c)) begin
          case (address[3:0])
            OFS_CTRL:   rdata = {28'b0, ctrl_v[c]};
            OFS_RELOAD: rdata = 32'(reload_v[c]);
            OFS_WINDOW: rdata = 32'(window_v[c]);
            OFS_TAP:    rdata = 32'(cnt_v[c]);
            default:    ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      pcnt_q       <= '0;
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      if (wr_en && address == ADDR_PRESCALE) begin
        presc_q <= wdata[PRESC_W-1:0];
        pcnt_q  <= '0;
      end else if (tick) begin
        pcnt_q <= '0;
      end else begin
        pcnt_q <= pcnt_q + PRESC_W'(1);
      end
      data_out_q   <= rdata;
      data_ready_q <= (data_read_n != 2'b11);
      irq_q        <= any_flag;
    end
  end

  assign data_out       = data_out_q;
  assign data_ready     = data_ready_q;
  assign user_interrupt = irq_q;
  assign uo_out         = uo_w;

endmodule

// File: tb/tb_tqvp_wdt_multi.sv
// Directed self-checking bench for tqvp_wdt_multi; all timing is counted in
// falling edges after the edge that captured the last bus write.
module tb_tqvp_wdt_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ui_in = 8'h00;
  logic [7:0]  uo_out;
  logic [5:0]  address = 6'h00;
  logic [31:0] data_in = 32'h0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int n_chk = 0;
  int n_fail = 0;

  tqvp_wdt_multi dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // All bus tasks start and end on a falling edge.
  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w = 2'b10);
    address = a; data_in = d; data_write_n = w;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d, output logic r);
    address = a; data_read_n = 2'b10;
    @(negedge clk);
    data_read_n = 2'b11;
    d = data_out; r = data_ready;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic r;
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if ({uo_out, user_interrupt, data_ready} !== 10'h0) begin n_fail++;
      $display("FAIL reset_outs: got uo=%h irq=%b rdy=%b required 0", uo_out, user_interrupt, data_ready); end
    n_chk++; if (data_out !== 32'h0) begin n_fail++;
      $display("FAIL reset_dout: got %h required 0", data_out); end
    rst_n = 1'b1;
    rd(6'h30, d, r);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h required 0", d); end
    n_chk++; if (r !== 1'b1) begin n_fail++; $display("FAIL read_ready: got %b required 1", r); end
    @(negedge clk);
    n_chk++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL ready_drop: got %b required 0", data_ready); end
    rd(6'h04, d, r);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_reload: got %h required 0", d); end
    rd(6'h3C, d, r);
    n_chk++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL unmapped_3c: got %h required ffffffff", d); end
    rd(6'h02, d, r);
    n_chk++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL unmapped_02: got %h required ffffffff", d); end
  endtask

  task automatic test_bark_bite();
    logic [31:0] d; logic r;
    do_reset();
    wr(6'h04, 32'd5);
    wr(6'h00, 32'h3);
    repeat (5) @(negedge clk);
    n_chk++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL bark_early: irq got %b required 0", user_interrupt); end
    @(negedge clk);
    n_chk++; if (user_interrupt !== 1'b1) begin n_fail++; $display("FAIL bark_time: irq got %b required 1", user_interrupt); end
    repeat (3) @(negedge clk);
    n_chk++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL bite_early: uo got %h required 00", uo_out); end
    @(negedge clk);
    n_chk++; if (uo_out !== 8'h01) begin n_fail++; $display("FAIL bite_time: uo got %h required 01", uo_out); end
    rd(6'h30, d, r);
    n_chk++; if (d !== 32'hA) begin n_fail++; $display("FAIL bite_status: got %h required 0000000a", d); end
    wr(6'h0C, 32'h0000_ABCD);
    wr(6'h38, 32'hFF);
    rd(6'h30, d, r);
    n_chk++; if (d !== 32'h9) begin n_fail++; $display("FAIL bite_sticky_status: got %h required 00000009", d); end
    n_chk++; if (uo_out !== 8'h01) begin n_fail++; $display("FAIL bite_sticky: uo got %h required 01", uo_out); end
  endtask

  task automatic test_prescale();
    logic [31:0] d; logic r;
    do_reset();
    wr(6'h34, 32'd3);
    wr(6'h04, 32'd2);
    wr(6'h00, 32'h3);
    repeat (6) @(negedge clk);
    n_chk++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL presc_early: irq got %b required 0", user_interrupt); end
    @(negedge clk);
    n_chk++; if (user_interrupt !== 1'b1) begin n_fail++; $display("FAIL presc_bark: irq got %b required 1", user_interrupt); end
    wr(6'h0C, 32'h0000_ABCD);
    rd(6'h30, d, r);
    n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL tap_clr_bark: status got %h required 00000001", d); end
    n_chk++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL tap_irq_drop: irq got %b required 0", user_interrupt); end
    wr(6'h0C, 32'h0000_ABCD);
    repeat (8) @(negedge clk);
    n_chk++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL tap_reload: irq got %b required 0", user_interrupt); end
    @(negedge clk);
    n_chk++; if (user_interrupt !== 1'b1) begin n_fail++; $display("FAIL tap_rebark: irq got %b required 1", user_interrupt); end
    rd(6'h34, d, r);
    n_chk++; if (d !== 32'h3) begin n_fail++; $display("FAIL presc_rb: got %h required 00000003", d); end
  endtask

  task automatic test_window();
    logic [31:0] d; logic r;
    do_reset();
    wr(6'h04, 32'd10);
    wr(6'h08, 32'd4);
    wr(6'h00, 32'h7);
    repeat (3) @(negedge clk);
    wr(6'h0C, 32'h0000_ABCD);
    rd(6'h30, d, r);
    n_chk++; if (d !== 32'h5) begin n_fail++; $display("FAIL early_status: got %h required 00000005", d); end
    n_chk++; if (user_interrupt !== 1'b1) begin n_fail++; $display("FAIL early_irq: got %b required 1", user_interrupt); end
    repeat (2) @(negedge clk);
    wr(6'h0C, 32'h0000_ABCD);
    wr(6'h38, 32'h2);
    rd(6'h30, d, r);
    n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL flt_clr_status: got %h required 00000001", d); end
    n_chk++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL flt_clr_irq: got %b required 0", user_interrupt); end
    repeat (2) @(negedge clk);
    n_chk++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL window_reload: irq got %b required 0", user_interrupt); end
  endtask

  task automatic test_bad_magic();
    logic [31:0] d; logic r;
    do_reset();
    wr(6'h04, 32'd5);
    wr(6'h00, 32'h3);
    wr(6'h0C, 32'h0000_1234);
    repeat (4) @(negedge clk);
    n_chk++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL badtap_early: irq got %b required 0", user_interrupt); end
    @(negedge clk);
    n_chk++; if (user_interrupt !== 1'b1) begin n_fail++; $display("FAIL badtap_bark: irq got %b required 1", user_interrupt); end
    rd(6'h30, d, r);
    n_chk++; if (d !== 32'h3) begin n_fail++; $display("FAIL badtap_status: got %h required 00000003", d); end
  endtask

  task automatic test_lock();
    logic [31:0] d; logic r;
    do_reset();
    wr(6'h04, 32'h1234_5678, 2'b00);
    rd(6'h04, d, r);
    n_chk++; if (d !== 32'h78) begin n_fail++; $display("FAIL byte_write: got %h required 00000078", d); end
    wr(6'h04, 32'h1234_5678, 2'b01);
    rd(6'h04, d, r);
    n_chk++; if (d !== 32'h5678) begin n_fail++; $display("FAIL half_write: got %h required 00005678", d); end
    wr(6'h14, 32'd7);
    wr(6'h10, 32'h8);
    wr(6'h14, 32'd99);
    rd(6'h14, d, r);
    n_chk++; if (d !== 32'd7) begin n_fail++; $display("FAIL lock_reload: got %h required 00000007", d); end
    wr(6'h10, 32'h3);
    rd(6'h10, d, r);
    n_chk++; if (d !== 32'h8) begin n_fail++; $display("FAIL lock_ctrl: got %h required 00000008", d); end
    wr(6'h04, 32'd99);
    rd(6'h04, d, r);
    n_chk++; if (d !== 32'd99) begin n_fail++; $display("FAIL ch0_writable: got %h required 00000063", d); end
    rd(6'h30, d, r);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL lock_status0: got %h required 00000000", d); end
    wr(6'h00, 32'hB);
    rd(6'h30, d, r);
    n_chk++; if (d !== 32'h8000_0001) begin n_fail++; $display("FAIL lock_bit31: got %h required 80000001", d); end
    rd(6'h00, d, r);
    n_chk++; if (d !== 32'hB) begin n_fail++; $display("FAIL ctrl_rb: got %h required 0000000b", d); end
  endtask

  task automatic test_disable();
    logic [31:0] d; logic r;
    do_reset();
    wr(6'h04, 32'd4);
    wr(6'h00, 32'h3);
    wr(6'h00, 32'h0);
    repeat (10) @(negedge clk);
    n_chk++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL frozen_irq: got %b required 0", user_interrupt); end
    rd(6'h30, d, r);
    n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL frozen_status: got %h required 00000001", d); end
    rd(6'h00, d, r);
    n_chk++; if (d !== 32'h2) begin n_fail++; $display("FAIL started_rb: got %h required 00000002", d); end
    wr(6'h00, 32'h1);
    repeat (3) @(negedge clk);
    n_chk++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL resume_early: irq got %b required 0", user_interrupt); end
    @(negedge clk);
    n_chk++; if (user_interrupt !== 1'b1) begin n_fail++; $display("FAIL resume_bark: irq got %b required 1", user_interrupt); end
  endtask

  task automatic test_tap_expiry_and_reset();
    logic [31:0] d; logic r;
    do_reset();
    wr(6'h04, 32'd3);
    wr(6'h00, 32'h3);
    repeat (2) @(negedge clk);
    wr(6'h0C, 32'hFFFF_ABCD, 2'b01);
    @(negedge clk);
    n_chk++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL tap_on_expiry: irq got %b required 0", user_interrupt); end
    address = 6'h30;
    repeat (3) @(negedge clk);
    n_chk++; if (user_interrupt !== 1'b1) begin n_fail++; $display("FAIL post_tap_bark: irq got %b required 1", user_interrupt); end
    rst_n = 1'b0;
    #1;
    n_chk++; if ({uo_out, user_interrupt, data_out} !== 41'h0) begin n_fail++;
      $display("FAIL mid_reset: got uo=%h irq=%b dout=%h required 0", uo_out, user_interrupt, data_out); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_chk++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL stopped_irq: got %b required 0", user_interrupt); end
    rd(6'h30, d, r);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL stopped_status: got %h required 00000000", d); end
  endtask

  initial begin
    test_reset();
    test_bark_bite();
    test_prescale();
    test_window();
    test_bad_magic();
    test_lock();
    test_disable();
    test_tap_expiry_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
